// File: rtl/lock_pkg.sv
// Shared types and helpers for the locked priority interrupt controller.
package lock_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ARMED = 2'd2
  } state_e;

  // The only nibble that makes a key-gate behave as AND(req, grp_en).
  localparam logic [3:0] KEYGATE_AND_NIBBLE = 4'b1000;

  function automatic logic mux4(input logic [3:0] nibble, input logic [1:0] sel);
    return nibble[sel];
  endfunction

endpackage

// File: rtl/locked_prio_intc_seq_if.sv
// Request, key-load and grant signals of the locked priority interrupt controller.
interface locked_prio_intc_seq_if #(
  parameter int unsigned NUM_GRP    = 3,
  parameter int unsigned CH_PER_GRP = 9
);
  localparam int unsigned NUM_CH = NUM_GRP * CH_PER_GRP;
  localparam int unsigned GW     = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
  localparam int unsigned CW     = (CH_PER_GRP > 1) ? $clog2(CH_PER_GRP) : 1;

  logic [NUM_CH-1:0]  req;
  logic [NUM_GRP-1:0] grp_en;
  logic               key_bit;
  logic               key_valid;
  logic               key_ready;
  logic               key_start;
  logic               armed;
  logic               gnt_valid;
  logic               gnt_ready;
  logic [GW-1:0]      gnt_grp;
  logic [CW-1:0]      gnt_ch;
  logic [NUM_GRP-1:0] gnt_any;

  modport master (
    output req, grp_en, key_bit, key_valid, key_start, gnt_ready,
    input  key_ready, armed, gnt_valid, gnt_grp, gnt_ch, gnt_any
  );

  modport slave (
    input  req, grp_en, key_bit, key_valid, key_start, gnt_ready,
    output key_ready, armed, gnt_valid, gnt_grp, gnt_ch, gnt_any
  );

endinterface

// File: rtl/keygate_mux4.sv
// Single MUX4 key-gate: the key nibble is the truth table of f(req, en).
module keygate_mux4
  import lock_pkg::*;
(
  input  logic       req_i,
  input  logic       en_i,
  input  logic [3:0] key_i,
  output logic       q_o
);

  assign q_o = mux4(key_i, {req_i, en_i});

endmodule

// File: rtl/locked_prio_intc_seq.sv
// Key-locked, two-stage priority interrupt controller with serial key load
// and a valid/ready grant port.
module locked_prio_intc_seq
  import lock_pkg::*;
#(
  parameter int unsigned NUM_GRP      = 3,
  parameter int unsigned CH_PER_GRP   = 9,
  parameter int unsigned NUM_KEYGATES = 9
) (
  input logic                    CK,
  input logic                    RESET_N,
  locked_prio_intc_seq_if.slave  bus
);

  localparam int unsigned NUM_CH = NUM_GRP * CH_PER_GRP;
  localparam int unsigned KEY_W  = 4 * NUM_KEYGATES;
  localparam int unsigned CNTW   = (KEY_W > 1) ? $clog2(KEY_W) : 1;
  localparam int unsigned GW     = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
  localparam int unsigned CW     = (CH_PER_GRP > 1) ? $clog2(CH_PER_GRP) : 1;
  localparam logic [CNTW-1:0] LAST_BIT = CNTW'(KEY_W - 1);

  state_e             state_q;
  logic [KEY_W-1:0]   key_q;
  logic [CNTW-1:0]    count_q;
  logic               key_ready_q;
  logic               armed_q;

  logic [NUM_CH-1:0]  q;
  logic [NUM_CH-1:0]  s1_q;
  logic               gnt_valid_q;
  logic [GW-1:0]      gnt_grp_q;
  logic [CW-1:0]      gnt_ch_q;
  logic [NUM_GRP-1:0] gnt_any_q;

  logic [NUM_GRP-1:0]    any_grp;
  logic [GW-1:0]         win_grp;
  logic [CW-1:0]         win_ch;
  logic [CH_PER_GRP-1:0] win_vec;
  logic                  stall;

  // Key load FSM; key_ready/armed are registered alongside the state.
  always_ff @(posedge CK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      key_q       <= '0;
      count_q     <= '0;
      key_ready_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.key_start) begin
            state_q     <= LOAD;
            count_q     <= '0;
            key_ready_q <= 1'b1;
          end
        end
        LOAD: begin
          if (bus.key_start) begin
            count_q <= '0;
          end else if (bus.key_valid) begin
            key_q[count_q] <= bus.key_bit;
            if (count_q == LAST_BIT) begin
              count_q     <= '0;
              state_q     <= ARMED;
              key_ready_q <= 1'b0;
              armed_q     <= 1'b1;
            end else begin
              count_q <= count_q + CNTW'(1);
            end
          end
        end
        ARMED: begin
          if (bus.key_start) begin
            state_q     <= LOAD;
            count_q     <= '0;
            key_ready_q <= 1'b1;
            armed_q     <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          key_ready_q <= 1'b0;
          armed_q     <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_qual
    localparam int unsigned G = i / CH_PER_GRP;
    if (i < NUM_KEYGATES) begin : g_kg
      keygate_mux4 u_kg (
        .req_i (bus.req[i]),
        .en_i  (bus.grp_en[G]),
        .key_i (key_q[4*i +: 4]),
        .q_o   (q[i])
      );
    end else begin : g_and
      assign q[i] = bus.req[i] & bus.grp_en[G];
    end
  end

  // Lowest group wins, then lowest channel inside it; loops run high-to-low.
  always_comb begin
    any_grp = '0;
    win_grp = '0;
    win_ch  = '0;
    win_vec = '0;
    for (int g = NUM_GRP - 1; g >= 0; g--) begin
      any_grp[g] = |s1_q[g*CH_PER_GRP +: CH_PER_GRP];
      if (any_grp[g]) begin
        win_grp = GW'(g);
        win_vec = s1_q[g*CH_PER_GRP +: CH_PER_GRP];
      end
    end
    for (int c = CH_PER_GRP - 1; c >= 0; c--) begin
      if (win_vec[c]) win_ch = CW'(c);
    end
  end

  assign stall = gnt_valid_q & ~bus.gnt_ready;

  always_ff @(posedge CK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_q        <= '0;
      gnt_valid_q <= 1'b0;
      gnt_grp_q   <= '0;
      gnt_ch_q    <= '0;
      gnt_any_q   <= '0;
    end else if (state_q != ARMED || bus.key_start) begin
      s1_q        <= '0;
      gnt_valid_q <= 1'b0;
      gnt_grp_q   <= '0;
      gnt_ch_q    <= '0;
      gnt_any_q   <= '0;
    end else if (!stall) begin
      s1_q        <= q;
      gnt_valid_q <= |s1_q;
      gnt_any_q   <= any_grp;
      if (|s1_q) begin
        gnt_grp_q <= win_grp;
        gnt_ch_q  <= win_ch;
      end
    end
  end

  assign bus.key_ready = key_ready_q;
  assign bus.armed     = armed_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_grp   = gnt_grp_q;
  assign bus.gnt_ch    = gnt_ch_q;
  assign bus.gnt_any   = gnt_any_q;

endmodule

// File: tb/tb_locked_prio_intc_seq.sv
// Directed self-checking bench for locked_prio_intc_seq.
module tb_locked_prio_intc_seq;
  import lock_pkg::*;

  localparam int unsigned KEY_W = 36;

  logic CK = 1'b0;
  logic RESET_N;
  int   checks = 0;
  int   failures = 0;
  int   ready_cycles;
  logic [KEY_W-1:0] good_key;
  logic [KEY_W-1:0] bad_key;

  locked_prio_intc_seq_if bus ();

  locked_prio_intc_seq dut (
    .CK      (CK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 CK = ~CK;

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_key(input logic [KEY_W-1:0] k);
    bus.key_start = 1'b1;
    tick();
    bus.key_start = 1'b0;
    bus.key_valid = 1'b1;
    ready_cycles = 0;
    for (int i = 0; i < KEY_W; i++) begin
      if (bus.key_ready === 1'b1) ready_cycles++;
      if (i == KEY_W - 1) check("armed_before_last_bit", 64'(bus.armed), 64'd0);
      bus.key_bit = k[i];
      tick();
    end
    bus.key_valid = 1'b0;
    if (bus.key_ready === 1'b1) ready_cycles++;
    check("key_ready_cycles", 64'(ready_cycles), 64'd36);
    check("armed_after_load", 64'(bus.armed), 64'd1);
    check("count_after_load", 64'(dut.count_q), 64'd0);
  endtask

  task automatic check_gnt(input string tag, input logic v, input logic [1:0] g,
                           input logic [3:0] c, input logic [2:0] a);
    check({tag, "_valid"}, 64'(bus.gnt_valid), 64'(v));
    check({tag, "_grp"},   64'(bus.gnt_grp),   64'(g));
    check({tag, "_ch"},    64'(bus.gnt_ch),    64'(c));
    check({tag, "_any"},   64'(bus.gnt_any),   64'(a));
  endtask

  initial begin
    good_key      = {9{KEYGATE_AND_NIBBLE}};
    bad_key       = good_key;
    bad_key[3:0]  = 4'b0001;
    RESET_N       = 1'b0;
    bus.req       = '0;
    bus.grp_en    = '0;
    bus.key_bit   = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_start = 1'b0;
    bus.gnt_ready = 1'b1;
    tick();
    tick();
    check("rst_key_ready", 64'(bus.key_ready), 64'd0);
    check("rst_armed", 64'(bus.armed), 64'd0);
    check_gnt("rst", 1'b0, 2'd0, 4'd0, 3'b000);
    RESET_N = 1'b1;
    tick();

    // Key bits offered while idle must be ignored.
    bus.key_valid = 1'b1;
    bus.key_bit   = 1'b1;
    tick();
    tick();
    bus.key_valid = 1'b0;
    check("idle_key_ignored", 64'(dut.key_q), 64'd0);
    check("idle_state", 64'(dut.state_q), 64'(IDLE));

    load_key(good_key);

    // Channels 5 and 20, all groups enabled.
    bus.grp_en = 3'b111;
    bus.req    = 27'(1) << 5 | 27'(1) << 20;
    tick();
    check("lat1_valid", 64'(bus.gnt_valid), 64'd0);
    tick();
    check_gnt("g0c5", 1'b1, 2'd0, 4'd5, 3'b101);

    // Stall: requests change to channel 10 while the consumer is busy.
    bus.gnt_ready = 1'b0;
    bus.req       = 27'(1) << 10;
    for (int i = 0; i < 5; i++) tick();
    check_gnt("stall", 1'b1, 2'd0, 4'd5, 3'b101);
    bus.gnt_ready = 1'b1;
    tick();
    check_gnt("xfer", 1'b1, 2'd0, 4'd5, 3'b101);
    tick();
    check_gnt("g1c1", 1'b1, 2'd1, 4'd1, 3'b010);

    // Group 0 disabled: channel 20 wins.
    bus.grp_en = 3'b110;
    bus.req    = 27'(1) << 5 | 27'(1) << 20;
    tick();
    tick();
    check_gnt("g2c2", 1'b1, 2'd2, 4'd2, 3'b100);

    // No requests: valid drops, grp/ch hold.
    bus.req = '0;
    tick();
    tick();
    check_gnt("idle_hold", 1'b0, 2'd2, 4'd2, 3'b000);

    // Wrong key on gate 0 turns a zero input into a request.
    bus.grp_en = '0;
    load_key(bad_key);
    tick();
    check("bad_lat1_valid", 64'(bus.gnt_valid), 64'd0);
    tick();
    check_gnt("badkey", 1'b1, 2'd0, 4'd0, 3'b001);

    // Reload, then reset part-way through the load.
    bus.key_start = 1'b1;
    tick();
    bus.key_start = 1'b0;
    check("reload_armed", 64'(bus.armed), 64'd0);
    check("reload_valid", 64'(bus.gnt_valid), 64'd0);
    check("reload_ready", 64'(bus.key_ready), 64'd1);
    bus.key_valid = 1'b1;
    bus.key_bit   = 1'b1;
    tick();
    tick();
    tick();
    #2;
    RESET_N = 1'b0;
    #1;
    check("arst_key_ready", 64'(bus.key_ready), 64'd0);
    check("arst_armed", 64'(bus.armed), 64'd0);
    check_gnt("arst", 1'b0, 2'd0, 4'd0, 3'b000);
    check("arst_key", 64'(dut.key_q), 64'd0);
    check("arst_count", 64'(dut.count_q), 64'd0);
    bus.key_valid = 1'b0;
    tick();
    RESET_N = 1'b1;
    tick();
    check("post_state", 64'(dut.state_q), 64'(IDLE));
    check("post_key_ready", 64'(bus.key_ready), 64'd0);
    check_gnt("post", 1'b0, 2'd0, 4'd0, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
